// File: rtl/spart_echo_top.sv
// spart_echo_top: DE1-SoC wrapper around a SPART (UART RX/TX + baud tick generator), 8N1.
// Latency: byte shown on LEDR/HEX one cycle after the stop-bit centre sample; echo starts on the following cycle.
// Backpressure: none on RX (a new byte overwrites an unread one); the echo holds RDA until TX is idle.
// Optional feature macro: SPART_ECHO_EN (echo received bytes on GPIO[3]; when undefined, TX is removed and GPIO[3]=1).
// Ports: CLOCK_50 clock, rst async active-high reset, SW[9:8] baud select (00=4800, 01=19200, 10=38400, 11=9600),
//        GPIO[5]=RXD in, GPIO[3]=TXD out, all other GPIO bits high-Z,
//        LEDR[7:0] last byte, LEDR[8] RDA, LEDR[9] sticky framing error, HEX1/HEX0 byte in hex, HEX2..HEX5 blank.
module spart_echo_top #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [9:0]  SW,
  inout  wire  [35:0] GPIO,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  // Divisor = round(CLK_FREQ / (OVERSAMPLE * baud)) - 1
  localparam logic [15:0] DIV_4800  = 16'((CLK_FREQ + OVERSAMPLE * 4800 / 2) / (OVERSAMPLE * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'((CLK_FREQ + OVERSAMPLE * 9600 / 2) / (OVERSAMPLE * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'((CLK_FREQ + OVERSAMPLE * 19200 / 2) / (OVERSAMPLE * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'((CLK_FREQ + OVERSAMPLE * 38400 / 2) / (OVERSAMPLE * 38400) - 1);
  localparam int          TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TLAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] THALF   = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} st_t;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [15:0]   baud_cnt_q, baud_cnt_d, div_sel;
  logic          tick;
  logic          rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
  st_t           rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0]    rx_bcnt_q, rx_bcnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic          rx_wait_q, rx_wait_d, rda_q, rda_d, ferr_q, ferr_d;
  logic          tx_load, txd;
  logic          unused_sw;

  assign unused_sw = ^SW[7:0];

  // The divisor is only picked up at reload, so a switch change never truncates a tick period.
  always_comb begin
    case (SW[9:8])
      2'b00:   div_sel = DIV_4800;
      2'b01:   div_sel = DIV_19200;
      2'b10:   div_sel = DIV_38400;
      default: div_sel = DIV_9600;
    endcase
    tick       = (baud_cnt_q == 16'd0);
    baud_cnt_d = tick ? div_sel : baud_cnt_q - 16'd1;
    rxd_meta_d = GPIO[5];
    rxd_sync_d = rxd_meta_q;
  end

  // RX state register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= DIV_9600;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      ferr_q     <= ferr_d;
    end
  end

  // RX next state
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_data_d  = rx_data_q;
    rda_d      = rda_q;
    ferr_d     = ferr_q;
    // A fresh byte below wins over a same-cycle consume.
    if (tx_load) rda_d = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (tick && !rxd_sync_q) begin
        rx_tcnt_d  = '0;
        rx_state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (rx_tcnt_q == THALF) begin
          // Mid start bit: a line back at 1 was only a glitch.
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end else rx_tcnt_d = rx_tcnt_q + TW'(1);
      end
      ST_DATA: if (tick) begin
        if (rx_tcnt_q == TLAST) begin
          rx_tcnt_d  = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bcnt_d  = rx_bcnt_q + 3'd1;
          if (rx_bcnt_q == 3'd7) rx_state_d = ST_STOP;
        end else rx_tcnt_d = rx_tcnt_q + TW'(1);
      end
      default: begin
        if (rx_wait_q) begin
          // Framing error: hold off until the line idles so a stuck-low line is not read as a new start.
          if (rxd_sync_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (tick) begin
          if (rx_tcnt_q == TLAST) begin
            rx_tcnt_d = '0;
            if (rxd_sync_q) begin
              rx_data_d  = rx_shift_q;
              rda_d      = 1'b1;
              rx_state_d = ST_IDLE;
            end else begin
              ferr_d    = 1'b1;
              rx_wait_d = 1'b1;
            end
          end else rx_tcnt_d = rx_tcnt_q + TW'(1);
        end
      end
    endcase
  end

  // RX/board outputs
  always_comb begin
    LEDR = {ferr_q, rda_q, rx_data_q};
    HEX0 = seg7(rx_data_q[3:0]);
    HEX1 = seg7(rx_data_q[7:4]);
    HEX2 = 7'h7F;
    HEX3 = 7'h7F;
    HEX4 = 7'h7F;
    HEX5 = 7'h7F;
  end

`ifdef SPART_ECHO_EN
  st_t           tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0]    tx_bcnt_q, tx_bcnt_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tbr;

  // TX state register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // TX next state; loads are only accepted in IDLE, so a load while busy is ignored.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      ST_IDLE: if (tx_load) begin
        tx_shift_d = rx_data_q;
        tx_tcnt_d  = '0;
        tx_state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (tx_tcnt_q == TLAST) begin
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
          tx_state_d = ST_DATA;
        end else tx_tcnt_d = tx_tcnt_q + TW'(1);
      end
      ST_DATA: if (tick) begin
        if (tx_tcnt_q == TLAST) begin
          tx_tcnt_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bcnt_d  = tx_bcnt_q + 3'd1;
          if (tx_bcnt_q == 3'd7) tx_state_d = ST_STOP;
        end else tx_tcnt_d = tx_tcnt_q + TW'(1);
      end
      default: if (tick) begin
        if (tx_tcnt_q == TLAST) begin
          tx_tcnt_d  = '0;
          tx_state_d = ST_IDLE;
        end else tx_tcnt_d = tx_tcnt_q + TW'(1);
      end
    endcase
  end

  // TX outputs
  always_comb begin
    tbr = (tx_state_q == ST_IDLE);
    case (tx_state_q)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = tx_shift_q[0];
      default:  txd = 1'b1;
    endcase
  end

  assign tx_load = rda_q & tbr;
`else
  assign tx_load = 1'b0;
  assign txd     = 1'b1;
`endif

  assign GPIO[3] = txd;
  for (genvar i = 0; i < 36; i++) begin : g_gpio_z
    if (i != 3 && i != 5) begin : g_z
      assign GPIO[i] = 1'bz;
    end
  end

endmodule

// File: tb/tb_spart_echo_top.sv
// Directed bench for spart_echo_top at a reduced clock frequency so frames stay short.
// CLK_FREQ = 5 MHz: 9600 -> div 32 (528 clk/bit), 4800 -> div 64 (1040), 19200 -> div 15 (256).
module tb_spart_echo_top;

  localparam int BIT_9600  = 518;  // sender slightly fast, as in the board test
  localparam int BIT_19200 = 260;
  localparam int TXBIT     = 528;  // DUT bit period at 9600

`ifdef SPART_ECHO_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sw  = 10'h300;
  logic        rxd_drv = 1'b1;
  wire  [35:0] gpio;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  int          total = 0;
  int          bad   = 0;

  assign gpio[5] = rxd_drv;

  always #10 clk = ~clk;

  spart_echo_top #(.CLK_FREQ(5000000), .OVERSAMPLE(16)) dut (
    .CLOCK_50(clk), .rst(rst), .SW(sw), .GPIO(gpio), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bitclk);
    rxd_drv = 1'b0;
    cyc(bitclk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      cyc(bitclk);
    end
    rxd_drv = stop_bit;
    cyc(bitclk);
    if (!stop_bit) cyc(bitclk);
    rxd_drv = 1'b1;
  endtask

`ifdef SPART_ECHO_EN
  task automatic tx_capture(output logic [9:0] bits_o);
    int n;
    n = 0;
    bits_o = 'x;
    while (gpio[3] !== 1'b0 && n < 20 * TXBIT) begin
      @(negedge clk);
      n++;
    end
    if (n < 20 * TXBIT) begin
      repeat (TXBIT / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bits_o[i] = gpio[3];
        if (i < 9) repeat (TXBIT) @(negedge clk);
      end
    end
  endtask
`endif

  initial begin
`ifdef SPART_ECHO_EN
    logic [9:0] cap;
`endif
    // Reset
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_hex0", 32'(hex0), 32'h40);
    chk("rst_hex1", 32'(hex1), 32'h40);
    chk("rst_hex2", 32'(hex2), 32'h7F);
    chk("rst_hex3", 32'(hex3), 32'h7F);
    chk("rst_hex4", 32'(hex4), 32'h7F);
    chk("rst_hex5", 32'(hex5), 32'h7F);
    chk("rst_txd",  32'(gpio[3]), 32'h1);
    cyc(BIT_9600);

    // 0x84 at 9600
`ifdef SPART_ECHO_EN
    fork
      send_byte(8'h84, 1'b1, BIT_9600);
      tx_capture(cap);
    join
    chk("echo_frame_84", 32'(cap), 32'h308);
`else
    send_byte(8'h84, 1'b1, BIT_9600);
`endif
    @(negedge clk);
    chk("b84_data", 32'(ledr[7:0]), 32'h84);
    chk("b84_rda",  32'(ledr[8]), 32'(!ECHO));
    chk("b84_hex1", 32'(hex1), 32'h00);
    chk("b84_hex0", 32'(hex0), 32'h19);
    chk("b84_ferr", 32'(ledr[9]), 32'h0);
    cyc(BIT_9600);

    // 0x55 with a bad stop bit, then a good 0x3C
    send_byte(8'h55, 1'b0, BIT_9600);
    cyc(BIT_9600);
    @(negedge clk);
    chk("ferr_data_kept", 32'(ledr[7:0]), 32'h84);
    chk("ferr_set",       32'(ledr[9]), 32'h1);
    send_byte(8'h3C, 1'b1, BIT_9600);
    @(negedge clk);
    chk("b3c_data", 32'(ledr[7:0]), 32'h3C);
    chk("b3c_ferr_sticky", 32'(ledr[9]), 32'h1);
    chk("b3c_hex1", 32'(hex1), 32'h30);
    chk("b3c_hex0", 32'(hex0), 32'h46);
    cyc(2 * TXBIT * 10);

    // Glitch shorter than half a bit at 4800 (half bit = 520 clocks)
    sw = 10'h000;
    cyc(200);
    rxd_drv = 1'b0;
    cyc(300);
    rxd_drv = 1'b1;
    cyc(3 * 1040);
    @(negedge clk);
    chk("glitch_data", 32'(ledr[7:0]), 32'h3C);
    chk("glitch_rda",  32'(ledr[8]), 32'(!ECHO));

    // 0xA3 at 19200
    sw = 10'h100;
    cyc(200);
    send_byte(8'hA3, 1'b1, BIT_19200);
    @(negedge clk);
    chk("ba3_data", 32'(ledr[7:0]), 32'hA3);
    chk("ba3_hex1", 32'(hex1), 32'h08);
    chk("ba3_hex0", 32'(hex0), 32'h30);
    cyc(BIT_19200);

    // Reset in the middle of a 0x5A frame
    rxd_drv = 1'b0;
    cyc(BIT_19200);
    for (int i = 0; i < 4; i++) begin
      rxd_drv = (8'h5A >> i) & 8'h01;
      cyc(BIT_19200);
    end
    rst = 1'b1;
    #1;
    chk("midrst_ledr", 32'(ledr), 32'h0);
    chk("midrst_hex0", 32'(hex0), 32'h40);
    chk("midrst_txd",  32'(gpio[3]), 32'h1);
    cyc(2);
    rst = 1'b0;
    rxd_drv = 1'b1;
    cyc(3 * BIT_19200);
    @(negedge clk);
    chk("midrst_nolatch", 32'(ledr), 32'h0);
    chk("midrst_txd_idle", 32'(gpio[3]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
